ov7670_dvp_tx: RTL
==================

Name: ov7670_dvp_tx

Overview:
- Transmit side of the OV7670-style DVP pixel bus.
- Reads a 320x240 RGB565 frame from the frame-buffer BRAM read port and replays it as vsync/href/d byte traffic, timed to pclk.
- Serves as an in-fabric camera emulator for loopback checking of the capture path and for running the video pipeline without a sensor attached.
- Byte order is RGB565 high byte first, then low byte. This is the order the capture side assembles.

Parameters:
- H_ACTIVE, 320, pixels per active line; each line carries 2*H_ACTIVE bytes.
- V_ACTIVE, 240, active lines per frame.
- H_BLANK, 144, pclk cycles per line with href low after the active bytes; minimum 2.
- VSYNC_LINES, 3, line periods with vsync high.
- VBP_LINES, 17, blank line periods after vsync falls and before the first active line.
- VFP_LINES, 10, blank line periods after the last active line.
- AW, 17, frame-buffer address width.

Ports:
- pclk, input, 1: pixel clock; all logic is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: frames start only while high.
- mem_addr, output, AW: frame-buffer read address.
- mem_rdata, input, 16: RGB565 read data, valid exactly 1 cycle after mem_addr.
- vsync, output, 1: frame sync, active high.
- href, output, 1: high during active bytes.
- d, output, 8: pixel byte.
- frame_done, output, 1: one-cycle pulse at the end of the frame.

Behaviour:
- Reset values, all outputs registered: vsync=0, href=0, d=0, mem_addr=0, frame_done=0. FSM in IDLE, all counters cleared.
- Line period: LP = 2*H_ACTIVE + H_BLANK cycles. Column counter col runs 0..LP-1; line counter increments on wrap.
- FSM states:
  - IDLE: leaves when enable=1; goes to VSYNC with col=0 and line=0.
  - VSYNC: vsync=1 for VSYNC_LINES*LP cycles; mem_addr forced to 0. Then goes to VBP.
  - VBP: VBP_LINES*LP cycles. Then goes to ACTIVE.
  - ACTIVE: V_ACTIVE line periods.
    - href=1 for col 0..2*H_ACTIVE-1.
    - d = pixel[15:8] on even col, pixel[7:0] on odd col.
    - href=0 and d=0 for the rest of the line.
    - Then goes to VFP.
  - VFP: VFP_LINES*LP cycles. On the final cycle frame_done=1. Then goes to VSYNC if enable=1, else IDLE.
- Fetch pipeline:
  - The address for pixel k is presented on the cycle before that pixel's high byte. That cycle is the previous pixel's low byte, or col=LP-1 of the preceding line for pixel 0 of each line.
  - mem_rdata is latched on the edge that starts the high byte.
  - The low byte comes from the latched word, so mem_rdata need not stay stable.
  - mem_addr increments by 1 per pixel, runs 0..H_ACTIVE*V_ACTIVE-1, and is never advanced past the last pixel. At the end of the frame it holds 76799.
- enable=0 mid-frame: the current frame completes; IDLE is entered after frame_done.
- rst_n low at any time: immediate return to reset values, with href and vsync low the same instant. A partial frame is never resumed.
- Totals with defaults:
  - Frame = (3+17+240+10)*784 = 211680 cycles.
  - href pulses per frame = 240, each 640 cycles wide.

Optional Feature:
- Macro: OV7670_DVP_TX_PATTERN_EN.
- Defined: adds input pattern_sel (1 bit).
  - When pattern_sel=1, the pixel word comes from an internal generator instead of mem_rdata.
  - The generator makes 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in the order white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - mem_addr sequencing is unchanged.
  - pattern_sel is sampled only at VSYNC entry.
- Undefined: the port is absent and the pixel word is always mem_rdata.

Test Plan:
- Reset, then enable=1 with small parameters (H_ACTIVE=4, V_ACTIVE=3, H_BLANK=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1) and a BRAM model holding word = 16'hA000+addr:
  - vsync high 12 cycles; 3 href pulses of 8 cycles each.
  - Bytes A0,00,A0,01,A0,02,A0,03 on line 0 and A0,0B last on line 2.
  - frame_done once, on cycle 72.
- Default parameters, one frame:
  - 240 href pulses of 640 cycles; 211680 cycles between vsync rising edges.
  - Last mem_addr=76799; never 76800.
- enable deasserted in the middle of ACTIVE:
  - The frame finishes with all 240 lines.
  - frame_done pulses, then vsync stays 0 and IDLE holds.
- rst_n pulsed low for 3 cycles mid-line:
  - href=0, vsync=0, mem_addr=0 asynchronously.
  - After release with enable=1, a fresh frame starts with vsync and the first byte pair is pixel 0.
- Loopback into the capture block with a 240x320 random image:
  - 76800 capture writes, each captured word equal to the BRAM word at the same index.
- With OV7670_DVP_TX_PATTERN_EN and pattern_sel=1 at default size:
  - Line 0 pixels 0..39 are FFFF, pixels 40..79 are FFE0, and pixels 280..319 are 0000.

Source files
------------

// File: rtl/ov7670_dvp_tx.sv
// ov7670_dvp_tx: OV7670-style DVP transmitter (camera emulator).
// Replays an RGB565 frame from frame-buffer BRAM as vsync/href/d byte traffic.
// Each pixel is sent high byte first, then low byte.
// Optional build macro OV7670_DVP_TX_PATTERN_EN adds pattern_sel.
// When pattern_sel is set, 8 vertical colour bars replace the BRAM data.
//
// Timing model: the FSM and counters advance once per pclk. Every output is
// a flop loaded from the current counter state, so all outputs trail the
// counters by one cycle, in lockstep with each other.
// The address for pixel k is driven during the counter cycle before its high
// byte. The synchronous BRAM then returns the word during the high-byte
// counter cycle. On that cycle's closing edge, d is loaded with the high byte
// and the low byte is stored for the next cycle.
module ov7670_dvp_tx #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10,
  parameter int AW          = 17
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          enable,
`ifdef OV7670_DVP_TX_PATTERN_EN
  input  logic          pattern_sel,
`endif
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic          vsync,
  output logic          href,
  output logic [7:0]    d,
  output logic          frame_done
);

  localparam int LP        = 2 * H_ACTIVE + H_BLANK;
  localparam int NPIX      = H_ACTIVE * V_ACTIVE;
  localparam int COL_W     = $clog2(LP);
  localparam int MAX_A     = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int MAX_B     = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LINE_W    = $clog2(MAX_LINES + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LP - 1);
  localparam logic [COL_W-1:0] ACT_END   = COL_W'(2 * H_ACTIVE);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] line_limit;
  logic              col_last, line_last;

  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        d_q, d_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        lo_q, lo_d;

  logic              in_bytes;
  logic              hi_byte;
  logic [15:0]       pixel_src;

`ifdef OV7670_DVP_TX_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic              pat_q, pat_d;
  logic [COL_W-1:0]  pix_x;
  logic [15:0]       bar_color;

  // Colour-bar generator: bar index is the pixel column divided by bar width
  always_comb begin
    pix_x     = col_q >> 1;
    bar_color = 16'h0000;
    case (32'(pix_x) / BAR_W)
      0:       bar_color = 16'hFFFF;
      1:       bar_color = 16'hFFE0;
      2:       bar_color = 16'h07FF;
      3:       bar_color = 16'h07E0;
      4:       bar_color = 16'hF81F;
      5:       bar_color = 16'hF800;
      6:       bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  end

  // Pattern mode is latched once per frame, on entry to VSYNC
  always_comb begin
    pat_d     = pat_q;
    if (state_d == VSYNC && state_q != VSYNC) begin
      pat_d = pattern_sel;
    end
    pixel_src = pat_q ? bar_color : mem_rdata;
  end
`else
  // Without the generator the pixel word is always the BRAM data
  always_comb begin
    pixel_src = mem_rdata;
  end
`endif

  // Per-state line budget and counter end detection
  always_comb begin
    line_limit = '0;
    case (state_q)
      VSYNC:   line_limit = LINE_W'(VSYNC_LINES - 1);
      VBP:     line_limit = LINE_W'(VBP_LINES - 1);
      ACTIVE:  line_limit = LINE_W'(V_ACTIVE - 1);
      VFP:     line_limit = LINE_W'(VFP_LINES - 1);
      default: line_limit = '0;
    endcase
    col_last  = (col_q == COL_LAST);
    line_last = (line_q == line_limit);
  end

  // Next-state logic: column/line counters step the frame through its phases
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = VSYNC;
          col_d   = '0;
          line_d  = '0;
        end
      end
      default: begin
        col_d = col_last ? '0 : col_q + COL_W'(1);
        if (col_last) begin
          if (line_last) begin
            line_d = '0;
            case (state_q)
              VSYNC:   state_d = VBP;
              VBP:     state_d = ACTIVE;
              ACTIVE:  state_d = VFP;
              VFP:     state_d = enable ? VSYNC : IDLE;
              default: state_d = IDLE;
            endcase
          end else begin
            line_d = line_q + LINE_W'(1);
          end
        end
      end
    endcase
  end

  // Output and fetch datapath computed from the current counter cycle
  always_comb begin
    in_bytes     = (state_q == ACTIVE) && (col_q < ACT_END);
    hi_byte      = in_bytes && !col_q[0];
    vsync_d      = (state_q == VSYNC);
    href_d       = in_bytes;
    frame_done_d = (state_q == VFP) && col_last && line_last;
    lo_d         = hi_byte ? pixel_src[7:0] : lo_q;
    d_d          = 8'h00;
    if (hi_byte) begin
      d_d = pixel_src[15:8];
    end else if (in_bytes) begin
      d_d = lo_q;
    end
    mem_addr_d = mem_addr_q;
    if (state_d == VSYNC) begin
      mem_addr_d = '0;
    end else if (hi_byte && mem_addr_q != LAST_ADDR) begin
      mem_addr_d = mem_addr_q + AW'(1);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      line_q       <= '0;
      mem_addr_q   <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= 8'h00;
      frame_done_q <= 1'b0;
      lo_q         <= 8'h00;
`ifdef OV7670_DVP_TX_PATTERN_EN
      pat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      mem_addr_q   <= mem_addr_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      d_q          <= d_d;
      frame_done_q <= frame_done_d;
      lo_q         <= lo_d;
`ifdef OV7670_DVP_TX_PATTERN_EN
      pat_q        <= pat_d;
`endif
    end
  end

  assign mem_addr   = mem_addr_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign d          = d_q;
  assign frame_done = frame_done_q;

endmodule
